// File: rtl/pe_incha_parallel.sv
// Multi-lane convolution PE: captures one pixel window and produces OUT_CHANNEL quantised bytes.
// Output channels are issued NUM_PE at a time through a four-stage MAC/scale/clamp pipeline.
module pe_incha_parallel #(
    parameter int    IN_CHANNEL       = 3,
    parameter int    KERNEL_PTS       = 9,
    parameter int    OUT_CHANNEL      = 8,
    parameter int    NUM_PE           = 2,
    parameter string OUTPUT_MODE      = "relu",
    parameter int    KERNEL_BASE_ADDR = 23,
    parameter int    BIAS_BASE_ADDR   = KERNEL_BASE_ADDR + IN_CHANNEL * KERNEL_PTS * OUT_CHANNEL,
    parameter int    COEFF_ADDR       = BIAS_BASE_ADDR + OUT_CHANNEL
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [8*IN_CHANNEL*KERNEL_PTS-1:0]  i_data,
    input  logic                                i_valid,
    output logic                                pe_ready,
    output logic                                pe_ack,
    output logic [8*OUT_CHANNEL-1:0]            o_data,
    output logic                                o_valid,
    input  logic                                o_ready,
    input  logic [31:0]                         weight_wr_data,
    input  logic [31:0]                         weight_wr_addr,
    input  logic                                weight_wr_en
);
    localparam int NUM_TAPS   = IN_CHANNEL * KERNEL_PTS;
    localparam int NUM_GROUPS = OUT_CHANNEL / NUM_PE;
    localparam int ACC_W      = 17 + $clog2(NUM_TAPS);
    localparam int PROD_W     = ACC_W + 17;
    localparam int SUM_W      = PROD_W + 1;
    localparam int GRP_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam bit IS_RELU    = (OUTPUT_MODE == "relu");
    localparam logic [GRP_W-1:0]        LAST_GRP   = GRP_W'(NUM_GROUPS - 1);
    localparam logic signed [SUM_W-1:0] ROUND_HALF = SUM_W'(32'sd32768);

    typedef enum logic [1:0] {ST_IDLE, ST_COMPUTE, ST_DRAIN, ST_HOLD} state_t;

    state_t                       state_q, state_d;
    logic [GRP_W-1:0]             grp_q, grp_d;
    logic [8*NUM_TAPS-1:0]        data_q, data_d;
    logic signed [7:0]            kern_q [OUT_CHANNEL][NUM_TAPS];
    logic signed [7:0]            kern_d [OUT_CHANNEL][NUM_TAPS];
    logic signed [23:0]           bias_q [OUT_CHANNEL];
    logic signed [23:0]           bias_d [OUT_CHANNEL];
    logic [15:0]                  coeff_q, coeff_d;
    logic                         s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d, s3_vld_q, s3_vld_d;
    logic                         s1_last_q, s1_last_d, s2_last_q, s2_last_d, s3_last_q, s3_last_d;
    logic [GRP_W-1:0]             s1_grp_q, s1_grp_d, s2_grp_q, s2_grp_d, s3_grp_q, s3_grp_d;
    logic signed [ACC_W-1:0]      acc_q [NUM_PE];
    logic signed [ACC_W-1:0]      acc_d [NUM_PE];
    logic signed [PROD_W-1:0]     prod_q [NUM_PE];
    logic signed [PROD_W-1:0]     prod_d [NUM_PE];
    logic signed [SUM_W-1:0]      sum_s [NUM_PE];
    logic [7:0]                   res_q [NUM_PE];
    logic [7:0]                   res_d [NUM_PE];
    logic signed [ACC_W-1:0]      px_s, wt_s;
    logic [8*OUT_CHANNEL-1:0]     o_data_q, o_data_d;
    logic                         wr_hi_unused_s;

    assign wr_hi_unused_s = ^weight_wr_data[31:24];

    // Round-to-nearest has already been folded in; drop the 16 fraction bits and saturate.
    function automatic logic [7:0] quantise(input logic signed [SUM_W-1:0] s);
        logic signed [SUM_W-1:0] q;
        logic [7:0]              r;
        q = s >>> 16;
        if (IS_RELU) begin
            if (s[SUM_W-1])                    r = 8'd0;
            else if (q > SUM_W'(32'sd255))     r = 8'd255;
            else                               r = s[23:16];
        end else begin
            if (q > SUM_W'(32'sd127))          r = 8'h7F;
            else if (q < SUM_W'(-32'sd128))    r = 8'h80;
            else                               r = q[7:0];
        end
        return r;
    endfunction

    // Weight/bias/coefficient register file decode
    always_comb begin
        kern_d  = kern_q;
        bias_d  = bias_q;
        coeff_d = coeff_q;
        if (weight_wr_en) begin
            for (int c = 0; c < OUT_CHANNEL; c++) begin
                for (int t = 0; t < NUM_TAPS; t++) begin
                    if (weight_wr_addr == 32'(KERNEL_BASE_ADDR + c * NUM_TAPS + t)) kern_d[c][t] = weight_wr_data[7:0];
                    else kern_d[c][t] = kern_q[c][t];
                end
                if (weight_wr_addr == 32'(BIAS_BASE_ADDR + c)) bias_d[c] = weight_wr_data[23:0];
                else bias_d[c] = bias_q[c];
            end
            if (weight_wr_addr == 32'(COEFF_ADDR)) coeff_d = weight_wr_data[15:0];
            else coeff_d = coeff_q;
        end else begin
            coeff_d = coeff_q;
        end
    end

    // Weight storage survives reset so a reset does not force a reload
    always_ff @(posedge clk) begin
        kern_q  <= kern_d;
        bias_q  <= bias_d;
        coeff_q <= coeff_d;
    end

    // FSM state, group counter and captured window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grp_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            grp_q   <= grp_d;
            data_q  <= data_d;
        end
    end

    // FSM next state; DRAIN ends when the last group reaches the buffer-write stage
    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    state_d = ST_COMPUTE;
                    grp_d   = '0;
                    data_d  = i_data;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COMPUTE: begin
                if (grp_q == LAST_GRP) state_d = ST_DRAIN;
                else grp_d = grp_q + GRP_W'(1);
            end
            ST_DRAIN: begin
                if (s3_vld_q && s3_last_q) state_d = ST_HOLD;
                else state_d = ST_DRAIN;
            end
            ST_HOLD: begin
                if (o_ready) state_d = ST_IDLE;
                else state_d = ST_HOLD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        pe_ready = 1'b0;
        pe_ack   = 1'b0;
        o_valid  = 1'b0;
        case (state_q)
            ST_IDLE:  begin pe_ready = 1'b1; pe_ack = i_valid; end
            ST_HOLD:  o_valid = 1'b1;
            default:  o_valid = 1'b0;
        endcase
    end

    // Pipeline control plus lane arithmetic: MAC, coefficient scale, bias/round/clamp
    always_comb begin
        s1_vld_d  = (state_q == ST_COMPUTE);
        s1_last_d = (grp_q == LAST_GRP);
        s1_grp_d  = grp_q;
        s2_vld_d  = s1_vld_q;
        s2_last_d = s1_last_q;
        s2_grp_d  = s1_grp_q;
        s3_vld_d  = s2_vld_q;
        s3_last_d = s2_last_q;
        s3_grp_d  = s2_grp_q;
        px_s      = '0;
        wt_s      = '0;
        for (int k = 0; k < NUM_PE; k++) begin
            acc_d[k] = '0;
            for (int t = 0; t < NUM_TAPS; t++) begin
                px_s     = ACC_W'($signed({1'b0, data_q[8*t +: 8]}));
                wt_s     = ACC_W'(kern_q[int'(grp_q) * NUM_PE + k][t]);
                acc_d[k] = acc_d[k] + px_s * wt_s;
            end
            prod_d[k] = PROD_W'(acc_q[k]) * PROD_W'($signed({1'b0, coeff_q}));
            sum_s[k]  = SUM_W'(prod_q[k]) + SUM_W'(bias_q[int'(s2_grp_q) * NUM_PE + k]) + ROUND_HALF;
            res_d[k]  = quantise(sum_s[k]);
        end
    end

    // Lane pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;  s2_vld_q <= 1'b0;  s3_vld_q <= 1'b0;
            s1_last_q <= 1'b0; s2_last_q <= 1'b0; s3_last_q <= 1'b0;
            s1_grp_q <= '0;    s2_grp_q <= '0;    s3_grp_q <= '0;
            for (int k = 0; k < NUM_PE; k++) begin
                acc_q[k]  <= '0;
                prod_q[k] <= '0;
                res_q[k]  <= '0;
            end
        end else begin
            s1_vld_q <= s1_vld_d;   s2_vld_q <= s2_vld_d;   s3_vld_q <= s3_vld_d;
            s1_last_q <= s1_last_d; s2_last_q <= s2_last_d; s3_last_q <= s3_last_d;
            s1_grp_q <= s1_grp_d;   s2_grp_q <= s2_grp_d;   s3_grp_q <= s3_grp_d;
            acc_q  <= acc_d;
            prod_q <= prod_d;
            res_q  <= res_d;
        end
    end

    // Result buffer write
    always_comb begin
        o_data_d = o_data_q;
        for (int k = 0; k < NUM_PE; k++) begin
            if (s3_vld_q) o_data_d[8*(int'(s3_grp_q) * NUM_PE + k) +: 8] = res_q[k];
            else o_data_d[8*(int'(s3_grp_q) * NUM_PE + k) +: 8] = o_data_q[8*(int'(s3_grp_q) * NUM_PE + k) +: 8];
        end
    end

    // Result buffer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) o_data_q <= '0;
        else        o_data_q <= o_data_d;
    end

    assign o_data = o_data_q;
endmodule

// File: tb/tb_pe_incha_parallel.sv
// Bench for pe_incha_parallel: a relu and a linear instance share stimulus; a per-cycle
// reference model checks handshake, latency and results, with literal pins on known windows.
module tb_pe_incha_parallel;
    localparam int NT = 4, OC = 4, NPE = 2, LAT = 4, G = OC / NPE;
    localparam int KB = 23, BB = KB + NT * OC, CA = BB + OC;

    logic clk = 1'b0;
    logic rst_n, i_valid, o_ready, wr_en_r, wr_en_l;
    logic [8*NT-1:0] i_data;
    logic [31:0] wr_data, wr_addr;
    logic ready_r, ack_r, oval_r, ready_l, ack_l, oval_l;
    logic [8*OC-1:0] odata_r, odata_l;

    int checks = 0, passes = 0, cyc = 0;
    int m_kern [2][OC][NT];
    int m_bias [2][OC];
    int m_coeff [2];
    int ph = 0, done_cyc = 0;
    logic [31:0] m_odata [2];
    logic [31:0] m_pend [2];

    always #5 clk = ~clk;

    pe_incha_parallel #(.IN_CHANNEL(2), .KERNEL_PTS(2), .OUT_CHANNEL(OC), .NUM_PE(NPE), .OUTPUT_MODE("relu")) u_relu (
        .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_valid(i_valid), .pe_ready(ready_r), .pe_ack(ack_r),
        .o_data(odata_r), .o_valid(oval_r), .o_ready(o_ready),
        .weight_wr_data(wr_data), .weight_wr_addr(wr_addr), .weight_wr_en(wr_en_r));

    pe_incha_parallel #(.IN_CHANNEL(2), .KERNEL_PTS(2), .OUT_CHANNEL(OC), .NUM_PE(NPE), .OUTPUT_MODE("linear")) u_lin (
        .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_valid(i_valid), .pe_ready(ready_l), .pe_ack(ack_l),
        .o_data(odata_l), .o_valid(oval_l), .o_ready(o_ready),
        .weight_wr_data(wr_data), .weight_wr_addr(wr_addr), .weight_wr_en(wr_en_l));

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    endtask

    task automatic tmo(input string name);
        checks++;
        $display("FAIL timeout waiting for %s @cyc %0d", name, cyc);
    endtask

    // Reference arithmetic: integer MAC, scale by coeff/2^16, add bias and half LSB, floor, clamp
    function automatic longint exp_chan(input int d, input logic [31:0] data, input int c);
        longint acc, s, q;
        acc = 0;
        for (int t = 0; t < NT; t++) acc += longint'(data[8*t +: 8]) * longint'(m_kern[d][c][t]);
        s = acc * longint'(m_coeff[d]) + longint'(m_bias[d][c]) + 64'sd32768;
        q = s >>> 16;
        if (d == 0) return (s < 0) ? 64'sd0 : (q > 255) ? 64'sd255 : q;
        return (q > 127) ? 64'sd127 : (q < -128) ? 64'sd128 : (q & 64'sd255);
    endfunction

    function automatic logic [31:0] exp_word(input int d, input logic [31:0] data);
        logic [31:0] w;
        for (int c = 0; c < OC; c++) w[8*c +: 8] = 8'(exp_chan(d, data, c));
        return w;
    endfunction

    task automatic wr(input int d, input int addr, input logic [31:0] val);
        wr_addr = 32'(addr);
        wr_data = val;
        if (d == 0) wr_en_r = 1'b1; else wr_en_l = 1'b1;
        if (addr >= KB && addr < BB) m_kern[d][(addr - KB) / NT][(addr - KB) % NT] = int'($signed(val[7:0]));
        else if (addr >= BB && addr < CA) m_bias[d][addr - BB] = int'($signed(val[23:0]));
        else if (addr == CA) m_coeff[d] = int'(val[15:0]);
        @(posedge clk); #1;
        wr_en_r = 1'b0;
        wr_en_l = 1'b0;
    endtask

    task automatic send(input logic [31:0] d);
        int n;
        n = 0;
        i_data = d;
        i_valid = 1'b1;
        #1;
        while (!ack_r && n < 50) begin @(posedge clk); #2; n++; end
        if (!ack_r) tmo("pe_ack");
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic wait_out(input int hold);
        int n;
        n = 0;
        while (!oval_r && n < 50) begin @(posedge clk); #1; n++; end
        if (!oval_r) tmo("o_valid");
        repeat (hold) begin @(posedge clk); #1; end
        o_ready = 1'b1;
        @(posedge clk); #1;
        o_ready = 1'b0;
    endtask

    // Per-cycle comparison against the reference model, sampled on the falling edge
    always @(negedge clk) begin
        logic rdy [2], ack [2], ov [2];
        logic [31:0] od [2];
        cyc++;
        rdy[0] = ready_r; ack[0] = ack_r; ov[0] = oval_r; od[0] = odata_r;
        rdy[1] = ready_l; ack[1] = ack_l; ov[1] = oval_l; od[1] = odata_l;
        if (!rst_n) begin
            ph = 0;
            for (int d = 0; d < 2; d++) begin
                m_odata[d] = '0;
                chk($sformatf("reset pe_ack d%0d", d), ack[d], 0);
                chk($sformatf("reset o_valid d%0d", d), ov[d], 0);
                chk($sformatf("reset o_data d%0d", d), od[d], 0);
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("pe_ready d%0d", d), rdy[d], (ph == 0));
                chk($sformatf("pe_ack d%0d", d), ack[d], (ph == 0 && i_valid));
                chk($sformatf("o_valid d%0d", d), ov[d], (ph == 2));
                if (ph != 1) chk($sformatf("o_data d%0d", d), od[d], m_odata[d]);
            end
            if (ph == 0 && i_valid) begin
                ph = 1;
                done_cyc = cyc + G + LAT;
                for (int d = 0; d < 2; d++) m_pend[d] = exp_word(d, i_data);
            end else if (ph == 1 && cyc + 1 == done_cyc) begin
                ph = 2;
                for (int d = 0; d < 2; d++) m_odata[d] = m_pend[d];
            end else if (ph == 2 && o_ready) begin
                ph = 0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        rst_n = 1'b0; i_valid = 1'b0; o_ready = 1'b0; i_data = '0;
        wr_en_r = 1'b0; wr_en_l = 1'b0; wr_data = '0; wr_addr = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Baseline weights: only tap 0 active, relu +1, linear -1, coeff 0.5
        for (int c = 0; c < OC; c++) begin
            for (int t = 0; t < NT; t++) begin
                wr(0, KB + c * NT + t, (t == 0) ? 32'h01 : 32'h00);
                wr(1, KB + c * NT + t, (t == 0) ? 32'hFF : 32'h00);
            end
            wr(0, BB + c, 32'h0);
            wr(1, BB + c, 32'h0);
        end
        wr(0, CA, 32'h8000);
        wr(1, CA, 32'h8000);

        send(32'h03C84D0A);
        wait_out(0);
        chk("w1 relu literal", odata_r, 32'h05050505);
        chk("w1 linear literal", odata_l, 32'hFBFBFBFB);

        wr(0, KB + 1 * NT, 32'hFF);
        wr(1, KB + 2 * NT, 32'h80);
        wr(1, CA, 32'hFFFF);
        wr(0, 100, 32'h7F);
        wr(1, KB - 1, 32'h55);
        wr(0, CA + 1, 32'h1234);
        send(32'h03C84D0A);
        wait_out(0);
        chk("w2 relu literal", odata_r, 32'h05050005);
        chk("w2 linear literal", odata_l, 32'hF680F6F6);

        wr(0, KB + 3 * NT, 32'h7F);
        wr(0, CA, 32'hFFFF);
        send(32'h112233FF);
        wait_out(0);
        chk("w3 relu literal", odata_r, 32'hFFFF00FF);
        chk("w3 linear literal", odata_l, 32'h80808080);

        // Multi-tap weights with biases, including a bias write carrying junk upper bits
        wr(0, KB + 0, 32'h01); wr(0, KB + 1, 32'h02); wr(0, KB + 2, 32'h03); wr(0, KB + 3, 32'h04);
        wr(0, KB + 4, 32'hFD); wr(0, KB + 5, 32'h05); wr(0, KB + 7, 32'h01);
        wr(0, KB + 8, 32'h7F); wr(0, KB + 9, 32'h80); wr(0, KB + 10, 32'h0A); wr(0, KB + 11, 32'hFF);
        wr(0, KB + 12, 32'h00); wr(0, KB + 15, 32'h02);
        wr(0, BB + 0, 32'h010000); wr(0, BB + 1, 32'hFFFF00); wr(0, BB + 3, 32'h7FFFFF);
        wr(0, CA, 32'h4000);
        wr(1, KB + 0, 32'h02); wr(1, KB + 1, 32'hFF); wr(1, KB + 2, 32'h01);
        wr(1, KB + 4, 32'hFB); wr(1, KB + 5, 32'h03); wr(1, KB + 6, 32'hFE); wr(1, KB + 7, 32'h07);
        wr(1, KB + 8, 32'h01); wr(1, KB + 9, 32'h01); wr(1, KB + 10, 32'h01); wr(1, KB + 11, 32'h01);
        wr(1, KB + 13, 32'h7F);
        wr(1, BB + 0, 32'hFE0000); wr(1, BB + 1, 32'hAB050000); wr(1, BB + 2, 32'h7FFFFF);
        wr(1, CA, 32'h0800);
        send(32'h03C83211);
        wait_out(0);

        // Output held 10 cycles with a pending window; it is captured right after acceptance
        send(32'hFF00FF80);
        i_data = 32'h12345678;
        i_valid = 1'b1;
        wait_out(10);
        #1 chk("hold release ack", ack_r, 1);
        @(posedge clk); #1;
        i_valid = 1'b0;
        wait_out(0);

        // Reset in the middle of COMPUTE, then a clean window with unchanged weights
        send(32'h0A0A0A0A);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        send(32'h0A0A0A0A);
        wait_out(0);

        // Back-to-back windows with o_ready held high
        o_ready = 1'b1;
        i_data = 32'h7F80FE01;
        i_valid = 1'b1;
        repeat (25) @(posedge clk);
        #1 i_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1 o_ready = 1'b0;
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/pe_incha_parallel.md
PE_INCHA_PARALLEL -- requirements
Module: pe_incha_parallel

Interface
REQ-001 SHALL have parameter IN_CHANNEL, default 3: input channels per pixel.
REQ-002 SHALL have parameter KERNEL_PTS, default 9: kernel points per channel; define NUM_TAPS = IN_CHANNEL*KERNEL_PTS.
REQ-003 SHALL have parameter OUT_CHANNEL, default 8: output channels; must be a multiple of NUM_PE.
REQ-004 SHALL have parameter NUM_PE, default 2: parallel MAC lanes; define NUM_GROUPS G = OUT_CHANNEL/NUM_PE.
REQ-005 SHALL have parameter OUTPUT_MODE, default "relu": "relu" for unsigned clamp, "linear" for signed clamp.
REQ-006 SHALL have parameters KERNEL_BASE_ADDR (23), BIAS_BASE_ADDR (KERNEL_BASE_ADDR+NUM_TAPS*OUT_CHANNEL) and COEFF_ADDR (BIAS_BASE_ADDR+OUT_CHANNEL).
REQ-007 clk  input  1  clock; all logic on the rising edge.
REQ-008 rst_n  input  1  reset; asynchronous, active-low.
REQ-009 i_data  input  8*NUM_TAPS  unsigned input bytes; tap t occupies bits [8t+7:8t].
REQ-010 i_valid  input  1  input window valid.
REQ-011 pe_ready  output  1  block can accept a window.
REQ-012 pe_ack  output  1  one-cycle pulse when a window is captured.
REQ-013 o_data  output  8*OUT_CHANNEL  results; channel c occupies bits [8c+7:8c].
REQ-014 o_valid  output  1  o_data valid.
REQ-015 o_ready  input  1  downstream accepts o_data.
REQ-016 weight_wr_data  input  32  weight write data.
REQ-017 weight_wr_addr  input  32  weight write address.
REQ-018 weight_wr_en  input  1  weight write strobe.

Function
REQ-019 SHALL store, on a write to KERNEL_BASE_ADDR+c*NUM_TAPS+t, weight_wr_data[7:0] as signed kernel byte (c,t).
REQ-020 SHALL store, on a write to BIAS_BASE_ADDR+c, weight_wr_data[23:0] as signed bias for channel c.
REQ-021 SHALL store, on a write to COEFF_ADDR, weight_wr_data[15:0] as unsigned coefficient (value x2^-16); other addresses are ignored.
REQ-022 SHALL use an FSM with states IDLE, COMPUTE, DRAIN and HOLD.
REQ-023 IDLE: pe_ready=1; on i_valid, pe_ack=1 for that cycle, i_data is registered, group counter is cleared, and the FSM goes to COMPUTE.
REQ-024 COMPUTE: pe_ready=0; issue one group per cycle, lanes k=0..NUM_PE-1 processing channel g*NUM_PE+k; after group G-1 go to DRAIN.
REQ-025 DRAIN: wait until the last group exits the pipeline, then go to HOLD with o_valid=1.
REQ-026 HOLD: o_data and o_valid SHALL stay stable until o_ready=1; on acceptance go to IDLE, with o_valid=0 next cycle.
REQ-027 SHALL ignore i_valid outside IDLE, and SHALL assert pe_ack only in IDLE.
REQ-028 Per lane: acc = sum over t of (unsigned data_t * signed w_t), signed, width 17+clog2(NUM_TAPS).
REQ-029 Per lane: p = acc*coeff, then s = p + bias + 0x8000, computed at full precision with no overflow.
REQ-030 relu: out = 0 if s<0; 255 if s>>16 > 255; else s[23:16].
REQ-031 linear: q = s>>>16 (arithmetic shift); out = clamp(q, -128, 127) as two's complement.
REQ-032 SHALL register each lane pipeline as issue -> MAC -> coeff -> bias/clamp -> buffer write, a latency of LAT=4 cycles.
REQ-033 SHALL assert o_valid exactly G+LAT cycles after the pe_ack cycle.
REQ-034 SHALL give undefined o_data for weight writes during COMPUTE/DRAIN, but the FSM timing and handshake SHALL be unaffected.
REQ-035 SHALL behave correctly with o_ready held high, giving back-to-back windows with one IDLE cycle between them.

Reset
REQ-036 On rst_n=0, at any time including mid-COMPUTE: FSM to IDLE; pe_ready=1 after release; pe_ack=0; o_valid=0; counters and pipeline valids cleared; o_data=0.
REQ-037 Weight storage SHALL NOT be cleared by reset.

Verification
REQ-038 Setup IN_CHANNEL=1, KERNEL_PTS=1, OUT_CHANNEL=4, NUM_PE=2, relu; weights 1, bias 0, coeff 0x8000; i_data=10 -> every channel 5, with o_valid exactly 6 cycles after pe_ack.
REQ-039 Same setup with channel 1 weight -1 (0xFF) -> channel 1 = 0 and the other channels = 5.
REQ-040 i_data=255, weight 127, coeff 0xFFFF -> 255 (saturation).
REQ-041 linear mode, weight -1, i_data=10, coeff 0x8000 -> 0xFB; weight -128, i_data=255, coeff 0xFFFF -> 0x80.
REQ-042 o_ready low for 10 cycles in HOLD while i_valid=1 -> o_data stable, pe_ready=0, no pe_ack; then o_ready=1 -> IDLE and the window is captured on the following cycle.
REQ-043 rst_n pulsed during COMPUTE -> no o_valid; the next window yields correct results with unchanged weights.
